// File: rtl/slave_rx_pkg.sv
// slave_rx_pkg: state encoding, latched transfer mode and default sizes for slave_rx_port
package slave_rx_pkg;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_BURST_WIDTH = 8;
    localparam int DEF_GAP_CYCLES  = 4;
    typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, WR_WAIT, RD_WAIT, DONE} state_t;
    typedef enum logic [1:0] {MODE_NONE, MODE_RD, MODE_WR} mode_t;
endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: register filled one indexed bit per enabled cycle, with whole-word increment
module serial_shift_in #(
    parameter int WIDTH = 8,
    parameter int IW    = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             inc,
    input  logic [IW-1:0]    idx,
    input  logic             din,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) value <= '0;
        else if (inc) value <= value + WIDTH'(1);
        else if (en) value[idx] <= din;
endmodule

// File: rtl/slave_rx_port.sv
// slave_rx_port: receives a serial LSB-first address (and write data), then sequences
// write beats on master handshakes or read beats paced by a minimum gap and master_ready.
module slave_rx_port
    import slave_rx_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_address,
    input  logic                   rx_data,
    input  logic                   master_valid,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   master_ready,
    output logic                   slave_ready,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic [DATA_WIDTH-1:0]  data,
    output logic                   rx_done,
    output logic                   read_en_in,
    output logic                   write_en_in,
    output logic [BURST_WIDTH-1:0] beat_count,
    output logic                   proto_err
);
    localparam int AIW = ADDR_WIDTH > 1 ? $clog2(ADDR_WIDTH) : 1;
    localparam int DIW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    state_t state, next_state;
    mode_t mode;
    logic [AIW-1:0] bit_cnt, a_idx;
    logic [DIW-1:0] d_idx;
    logic [BURST_WIDTH-1:0] burst_q;
    logic [GW-1:0] gap_cnt;
    logic hs, legal, start, beat_start, last, gap_done, rd_go, a_en, a_inc, d_en;

    assign slave_ready = state == IDLE || state == WR_WAIT;
    assign hs          = master_valid && slave_ready;
    assign legal       = read_en ^ write_en;
    assign start       = state == IDLE && hs && legal;
    assign beat_start  = state == WR_WAIT && hs;
    assign last        = beat_count == burst_q;
    assign gap_done    = gap_cnt == GW'(GAP_CYCLES);
    assign rd_go       = state == RD_WAIT && gap_done && master_ready;
    assign rx_done     = state == DONE;
    assign read_en_in  = rx_done && mode == MODE_RD;
    assign write_en_in = rx_done && mode == MODE_WR;

    // Bit 0 of each serial word is taken on the handshake itself, so the counter starts at 1.
    assign a_en  = start || state == ADDR;
    assign a_idx = state == ADDR ? bit_cnt : '0;
    assign a_inc = beat_start || rd_go;
    assign d_en  = (start && write_en) || beat_start || state == WR_DATA ||
                   (state == ADDR && mode == MODE_WR && 32'(bit_cnt) < DATA_WIDTH);
    assign d_idx = state == IDLE || state == WR_WAIT ? '0 : DIW'(bit_cnt);

    serial_shift_in #(.WIDTH(ADDR_WIDTH), .IW(AIW)) u_addr (
        .clk(clk), .reset_n(reset_n), .en(a_en), .inc(a_inc),
        .idx(a_idx), .din(rx_address), .value(address)
    );

    serial_shift_in #(.WIDTH(DATA_WIDTH), .IW(DIW)) u_data (
        .clk(clk), .reset_n(reset_n), .en(d_en), .inc(1'b0),
        .idx(d_idx), .din(rx_data), .value(data)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADDR_WIDTH == 1 ? DONE : ADDR;
            ADDR:    if (bit_cnt == AIW'(ADDR_WIDTH - 1)) next_state = DONE;
            WR_WAIT: if (hs) next_state = DATA_WIDTH == 1 ? DONE : WR_DATA;
            WR_DATA: if (bit_cnt == AIW'(DATA_WIDTH - 1)) next_state = DONE;
            RD_WAIT: if (rd_go) next_state = DONE;
            DONE:    next_state = last ? IDLE : mode == MODE_RD ? RD_WAIT : WR_WAIT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mode       <= MODE_NONE;
            bit_cnt    <= '0;
            burst_q    <= '0;
            beat_count <= '0;
            gap_cnt    <= '0;
            proto_err  <= 1'b0;
        end else begin
            proto_err <= state == IDLE && hs && !legal;
            bit_cnt   <= start || beat_start ? AIW'(1) : bit_cnt + AIW'(1);
            // Gap counter saturates so master_ready is honoured only after the quiet period.
            gap_cnt   <= state != RD_WAIT ? '0 : gap_done ? gap_cnt : gap_cnt + GW'(1);
            if (start) begin
                mode       <= write_en ? MODE_WR : MODE_RD;
                burst_q    <= burst_len;
                beat_count <= '0;
            end else if (state == DONE && !last) begin
                beat_count <= beat_count + BURST_WIDTH'(1);
            end
        end
endmodule

// File: tb/tb_slave_rx_port.sv
// tb_slave_rx_port: vector table, directed burst/stall/reset sequences and random
// transactions checked against a transaction-level timing model.
module tb_slave_rx_port;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int GAP = 4;

    logic clk = 0, reset_n = 0;
    logic rx_address = 0, rx_data = 0, master_valid = 0, read_en = 0, write_en = 0, master_ready = 0;
    logic [7:0] burst_len = 0;
    logic slave_ready, rx_done, read_en_in, write_en_in, proto_err;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic [7:0] beat_count;

    slave_rx_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(8), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .rx_address(rx_address), .rx_data(rx_data),
        .master_valid(master_valid), .read_en(read_en), .write_en(write_en),
        .burst_len(burst_len), .master_ready(master_ready), .slave_ready(slave_ready),
        .address(address), .data(data), .rx_done(rx_done), .read_en_in(read_en_in),
        .write_en_in(write_en_in), .beat_count(beat_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int addr; int dat; int beat; int re; int we;} ev_t;
    typedef struct {bit rd; bit wr; logic [11:0] addr; logic [7:0] dat;
                    int n_done; int n_proto; logic [11:0] e_addr; logic [7:0] e_data;} vec_t;

    int cyc, n_checks, n_fail, sr_mis, stray;
    ev_t got_q[$], exp_q[$];
    int got_p[$], exp_p[$];
    logic [11:0] maddr;
    logic [7:0] mdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1)
            got_q.push_back(ev_t'{cyc, int'(address), int'(data), int'(beat_count),
                                  int'(read_en_in), int'(write_en_in)});
        if (proto_err === 1'b1) got_p.push_back(cyc);
        if (rx_done !== 1'b1 && (read_en_in !== 1'b0 || write_en_in !== 1'b0)) stray++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input bit exp_ready);
        if (slave_ready !== exp_ready) sr_mis++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        master_valid = 0; read_en = 0; write_en = 0; rx_address = 0; rx_data = 0;
    endtask

    task automatic clear_obs();
        got_q.delete(); exp_q.delete(); got_p.delete(); exp_p.delete();
        sr_mis = 0; stray = 0;
    endtask

    task automatic compare(input string tag);
        int n;
        check($sformatf("%s n_done", tag), got_q.size(), exp_q.size());
        n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s ev%0d cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s ev%0d addr", tag, i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("%s ev%0d data", tag, i), got_q[i].dat, exp_q[i].dat);
            check($sformatf("%s ev%0d beat", tag, i), got_q[i].beat, exp_q[i].beat);
            check($sformatf("%s ev%0d rd/wr", tag, i), {got_q[i].re[0], got_q[i].we[0]},
                  {exp_q[i].re[0], exp_q[i].we[0]});
        end
        check($sformatf("%s n_proto", tag), got_p.size(), exp_p.size());
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++)
            check($sformatf("%s proto cyc", tag), got_p[i], exp_p[i]);
        check($sformatf("%s slave_ready mismatches", tag), sr_mis, 0);
        check($sformatf("%s stray rd/wr_en_in", tag), stray, 0);
        check($sformatf("%s addr hold", tag), address, maddr);
        check($sformatf("%s data hold", tag), data, mdata);
    endtask

    // Drives one transaction open-loop; expected timing comes from the protocol rules:
    // first done at T0+AW, write beat done at handshake+DW, read beat done one cycle after
    // the first master_ready=1 at least GAP cycles into the wait.
    task automatic run(input bit rd, input bit wr, input int blen, input logic [11:0] addr,
                       input logic [7:0] d [4], input int wgap, input int stall, input bit rnd);
        int t0, dcyc;
        bit v;
        logic [11:0] a;
        clear_obs();
        t0 = cyc;
        master_valid = 1; read_en = rd; write_en = wr; burst_len = 8'(blen);
        rx_address = addr[0]; rx_data = d[0][0]; master_ready = 1'($urandom);
        step(1);
        if (rd == wr) begin
            exp_p.push_back(t0 + 1);
            idle_in();
            step(1);
            step(1);
        end else begin
            for (int k = 1; k < AW; k++) begin
                master_valid = 1'($urandom); read_en = 1'($urandom); write_en = 1'($urandom);
                burst_len = 8'($urandom); rx_address = addr[k];
                rx_data = k < DW ? d[0][k] : 1'($urandom);
                step(0);
            end
            dcyc = t0 + AW;
            a = addr;
            if (wr) mdata = d[0];
            exp_q.push_back(ev_t'{dcyc, int'(a), int'(mdata), 0, int'(rd), int'(wr)});
            for (int i = 1; i <= blen; i++) begin
                if (wr) begin
                    idle_in();
                    master_valid = 1'($urandom);
                    step(0);
                    master_valid = 0;
                    for (int j = 1; j < wgap; j++) step(1);
                    master_valid = 1; rx_data = d[i][0];
                    step(1);
                    for (int k = 1; k < DW; k++) begin
                        master_valid = 1'($urandom); rx_data = d[i][k];
                        step(0);
                    end
                    dcyc = dcyc + wgap + DW;
                    mdata = d[i];
                end else begin
                    master_ready = 1'($urandom);
                    step(0);
                    for (int c = dcyc + 1; c < dcyc + 200; c++) begin
                        v = c > dcyc + stall && (!rnd || 1'($urandom) || c > dcyc + stall + 20);
                        master_ready = v; master_valid = 1'($urandom);
                        step(0);
                        if (c >= dcyc + 1 + GAP && v) begin
                            dcyc = c + 1;
                            break;
                        end
                    end
                end
                a = a + 12'd1;
                exp_q.push_back(ev_t'{dcyc, int'(a), int'(mdata), i, int'(rd), int'(wr)});
            end
            idle_in();
            step(0);
            maddr = a;
            check("slave_ready after done", slave_ready, 1);
        end
    endtask

    vec_t vecs[7];
    logic [7:0] dd [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        maddr = 0; mdata = 0;
        vecs[0] = '{1'b0, 1'b1, 12'hA5C, 8'h3C, 1, 0, 12'hA5C, 8'h3C};
        vecs[1] = '{1'b1, 1'b0, 12'h123, 8'hFF, 1, 0, 12'h123, 8'h3C};
        vecs[2] = '{1'b1, 1'b1, 12'h777, 8'h55, 0, 1, 12'h123, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 12'h456, 8'hAA, 0, 1, 12'h123, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 12'hFFF, 8'hFF, 1, 0, 12'hFFF, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 12'h000, 8'h00, 1, 0, 12'h000, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 12'h800, 8'hC3, 1, 0, 12'h800, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {rx_done, read_en_in, write_en_in, proto_err, address, data, beat_count}, 0);
        check("reset slave_ready", slave_ready, 1);
        reset_n = 1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            dd = '{vecs[i].dat, 8'h00, 8'h00, 8'h00};
            run(vecs[i].rd, vecs[i].wr, 0, vecs[i].addr, dd, 1, 0, 0);
            compare($sformatf("vec%0d", i));
            check($sformatf("vec%0d n_done", i), got_q.size(), vecs[i].n_done);
            check($sformatf("vec%0d n_proto", i), got_p.size(), vecs[i].n_proto);
            check($sformatf("vec%0d address", i), address, vecs[i].e_addr);
            check($sformatf("vec%0d data", i), data, vecs[i].e_data);
        end

        run(0, 1, 2, 12'h010, '{8'h11, 8'h22, 8'h33, 8'h00}, 2, 0, 0);
        compare("wr_burst");
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            check($sformatf("wr_burst addr%0d", i), got_q[i].addr, 32'h010 + i);
            check($sformatf("wr_burst data%0d", i), got_q[i].dat, 32'h11 * (i + 1));
        end

        run(1, 0, 3, 12'hFFE, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1, 0, 0);
        compare("rd_wrap");
        for (int i = 0; i < got_q.size() && i < 4; i++)
            check($sformatf("rd_wrap addr%0d", i), got_q[i].addr, (32'hFFE + i) % 4096);
        for (int i = 1; i < got_q.size(); i++)
            check($sformatf("rd_wrap spacing%0d", i), got_q[i].cyc - got_q[i-1].cyc, 6);

        run(1, 0, 1, 12'h3A0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1, 20, 0);
        compare("rd_stall");
        if (got_q.size() == 2) check("rd_stall spacing", got_q[1].cyc - got_q[0].cyc, 22);

        clear_obs();
        master_valid = 1; write_en = 1; read_en = 0; burst_len = 0;
        rx_address = 1; rx_data = 1;
        step(1);
        for (int k = 1; k < 5; k++) begin
            master_valid = 1'($urandom); rx_address = 1'($urandom); rx_data = 1'($urandom);
            step(0);
        end
        reset_n = 0;
        #1;
        check("async reset outputs", {rx_done, read_en_in, write_en_in, proto_err, address, data, beat_count}, 0);
        check("async reset slave_ready", slave_ready, 1);
        idle_in();
        @(posedge clk);
        #1;
        reset_n = 1;
        maddr = 0; mdata = 0;
        check("ready after release", slave_ready, 1);
        repeat (14) step(1);
        check("no done after reset", got_q.size(), 0);
        run(0, 1, 0, 12'h5A5, '{8'h96, 8'h00, 8'h00, 8'h00}, 1, 0, 0);
        compare("post_reset");

        for (int t = 0; t < 40; t++) begin
            int r;
            bit rd, wr;
            r = $urandom_range(0, 9);
            rd = r == 1 || r > 5;
            wr = r == 1 || (r >= 2 && r <= 5);
            for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
            run(rd, wr, $urandom_range(0, 3), 12'($urandom), dd, $urandom_range(1, 4),
                $urandom_range(0, 7), 1'($urandom));
            compare($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/slave_rx_port.md
SLAVE_RX_PORT -- requirements
Module: slave_rx_port

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 12, serial address bits per transaction; SHALL be >= DATA_WIDTH.
- DATA_WIDTH, 8, serial data bits per write beat.
- BURST_WIDTH, 8, width of burst_len.
- GAP_CYCLES, 4, minimum idle cycles between read-burst beats; SHALL be >= 1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- rx_address, in, 1, serial address, LSB first.
- rx_data, in, 1, serial write data, LSB first.
- master_valid, in, 1, master offers a transaction or write beat.
- read_en, in, 1, read request; sampled at the opening handshake.
- write_en, in, 1, write request; sampled at the opening handshake.
- burst_len, in, BURST_WIDTH, beats minus one; sampled at the opening handshake.
- master_ready, in, 1, master can accept the next read beat.
- slave_ready, out, 1, port can accept a handshake.
- address, out, ADDR_WIDTH, current beat address.
- data, out, DATA_WIDTH, current write-beat data.
- rx_done, out, 1, one-cycle pulse: address/data valid.
- read_en_in, out, 1, rx_done AND latched read.
- write_en_in, out, 1, rx_done AND latched write.
- beat_count, out, BURST_WIDTH, index of the current beat.
- proto_err, out, 1, one-cycle pulse: illegal request.

Function
REQ-003 Handshake SHALL be master_valid AND slave_ready; slave_ready SHALL be high only in IDLE and in WR_WAIT.
REQ-004 FSM states SHALL be IDLE, ADDR, WR_DATA, WR_WAIT, RD_WAIT, DONE.
REQ-005 IDLE + handshake at T0 with exactly one of read_en/write_en SHALL sample address bit 0, data bit 0 (write only), latch mode and burst_len, clear beat_count, and go to ADDR.
REQ-006 IDLE + handshake with read_en=write_en (both 0 or both 1) SHALL pulse proto_err at T0+1 and remain in IDLE.
REQ-007 ADDR SHALL sample one address bit per cycle (and data bits while fewer than DATA_WIDTH are taken, write only); after bit ADDR_WIDTH-1 it SHALL go to DONE, so rx_done is high at T0+ADDR_WIDTH.
REQ-008 DONE SHALL assert rx_done for exactly one cycle. If beat_count == latched burst_len, it SHALL go to IDLE. Otherwise it SHALL increment beat_count and go to WR_WAIT (write) or RD_WAIT (read).
REQ-009 WR_WAIT + handshake at Tb SHALL sample data bit 0 and go to WR_DATA; WR_DATA SHALL take the remaining DATA_WIDTH-1 bits; DONE SHALL follow at Tb+DATA_WIDTH with address = previous address + 1.
REQ-010 RD_WAIT SHALL ignore master_ready for GAP_CYCLES cycles after entry. After that, master_ready=1 SHALL increment address and enter DONE the next cycle. master_ready=0 SHALL hold RD_WAIT indefinitely.
REQ-011 Address increment SHALL wrap modulo 2^ADDR_WIDTH; there SHALL be no error on wrap.
REQ-012 master_valid deassertion mid-serial SHALL be ignored; a handshake while slave_ready=0 SHALL have no effect.
REQ-013 address and data SHALL hold their values outside sampling cycles; data SHALL be unchanged by reads.

Reset
REQ-014 reset_n low SHALL immediately force state IDLE and zero address, data, beat_count, latched mode and the gap counter; rx_done, read_en_in, write_en_in and proto_err SHALL be 0.
REQ-015 Reset mid-transaction SHALL abandon it with no rx_done; slave_ready SHALL be 1 from the first clock after release.

Structure
REQ-016 Package slave_rx_pkg SHALL hold the state encoding and default parameter constants.
REQ-017 One sub-module, serial_shift_in (parametrised WIDTH, enable, bit index), SHALL be instantiated twice: once for address, once for data.

Verification (ADDR_WIDTH=12, DATA_WIDTH=8, GAP_CYCLES=4)
REQ-018 Single write: write_en=1, burst_len=0, address 0xA5C, data 0x3C -> rx_done and write_en_in high at T0+12 only, address=0xA5C, data=0x3C, slave_ready=1 at T0+13.
REQ-019 Write burst: burst_len=2, address 0x010, beat data 0x11/0x22/0x33, each beat handshaked 2 cycles after the previous rx_done -> three rx_done pulses with addresses 0x010/0x011/0x012, data as sent, beat_count 0/1/2.
REQ-020 Read burst with wrap: read_en=1, burst_len=3, address 0xFFE, master_ready held 1 -> addresses 0xFFE/0xFFF/0x000/0x001, consecutive rx_done pulses 6 cycles apart, data unchanged.
REQ-021 Read stall: master_ready=0 for 20 cycles in RD_WAIT -> no rx_done and slave_ready=0 during the stall; rx_done 1 cycle after master_ready rises.
REQ-022 Illegal and reset: read_en=write_en=1 -> proto_err one cycle, no rx_done. reset_n low at T0+5 of a write -> all outputs 0, no rx_done, next transaction completes normally.
